// File: rtl/pbit_sample_decoder.sv
// Majority-vote decoder for the p-bit ripple adder: resets the adder, discards a burn-in
// interval, counts ones per bit over a programmable window, then reports settled words.
// Optional a+b == {ovf,s} hit counter is enabled by defining PBIT_CONSISTENCY_CHECK_EN.
module pbit_sample_decoder #(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 16,
    parameter int BURN_IN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] window,
    input  logic [WIDTH-1:0] a_smp,
    input  logic [WIDTH-1:0] b_smp,
    input  logic [WIDTH-1:0] s_smp,
    input  logic             ovf_smp,
    output logic             adder_reset,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] a_dec,
    output logic [WIDTH-1:0] b_dec,
    output logic [WIDTH-1:0] s_dec,
    output logic             ovf_dec,
    output logic [CNT_W-1:0] hit_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FLUSH  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DECIDE = 2'd3;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] BURN_LAST = CNT_W'(BURN_IN);

    logic [1:0]                  state_q, state_d;
    logic [CNT_W-1:0]            phase_q, phase_d;
    logic [CNT_W-1:0]            win_q, win_d;
    logic                        adder_reset_q, adder_reset_d;
    logic                        done_q, done_d;
    logic [WIDTH-1:0][CNT_W-1:0] a_cnt_q, a_cnt_d;
    logic [WIDTH-1:0][CNT_W-1:0] b_cnt_q, b_cnt_d;
    logic [WIDTH-1:0][CNT_W-1:0] s_cnt_q, s_cnt_d;
    logic [CNT_W-1:0]            ovf_cnt_q, ovf_cnt_d;
    logic [WIDTH-1:0]            a_dec_q, a_dec_d;
    logic [WIDTH-1:0]            b_dec_q, b_dec_d;
    logic [WIDTH-1:0]            s_dec_q, s_dec_d;
    logic                        ovf_dec_q, ovf_dec_d;

`ifdef PBIT_CONSISTENCY_CHECK_EN
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] hit_count_q, hit_count_d;
    logic [WIDTH:0]   pair_sum;
    logic             pair_hit;

    assign pair_sum = {1'b0, a_smp} + {1'b0, b_smp};
    assign pair_hit = (pair_sum == {ovf_smp, s_smp});
`endif

    // Strict majority at CNT_W+1 bits so 2*count cannot wrap; a tie decodes to 0.
    function automatic logic majority(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] win);
        return {cnt, 1'b0} > {1'b0, win};
    endfunction

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d       = state_q;
        phase_d       = phase_q;
        win_d         = win_q;
        adder_reset_d = 1'b0;
        done_d        = 1'b0;
        a_cnt_d       = a_cnt_q;
        b_cnt_d       = b_cnt_q;
        s_cnt_d       = s_cnt_q;
        ovf_cnt_d     = ovf_cnt_q;
        a_dec_d       = a_dec_q;
        b_dec_d       = b_dec_q;
        s_dec_d       = s_dec_q;
        ovf_dec_d     = ovf_dec_q;
`ifdef PBIT_CONSISTENCY_CHECK_EN
        hit_cnt_d     = hit_cnt_q;
        hit_count_d   = hit_count_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d       = FLUSH;
                    win_d         = (window == '0) ? ONE : window;
                    phase_d       = '0;
                    adder_reset_d = 1'b1;
                    a_cnt_d       = '0;
                    b_cnt_d       = '0;
                    s_cnt_d       = '0;
                    ovf_cnt_d     = '0;
`ifdef PBIT_CONSISTENCY_CHECK_EN
                    hit_cnt_d     = '0;
`endif
                end
            end

            FLUSH: begin
                if (phase_q == BURN_LAST) begin
                    state_d = SAMPLE;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + ONE;
                end
            end

            SAMPLE: begin
                // Counters never exceed the window, so plain adds cannot overflow.
                for (int i = 0; i < WIDTH; i++) begin
                    a_cnt_d[i] = a_cnt_q[i] + {{(CNT_W-1){1'b0}}, a_smp[i]};
                    b_cnt_d[i] = b_cnt_q[i] + {{(CNT_W-1){1'b0}}, b_smp[i]};
                    s_cnt_d[i] = s_cnt_q[i] + {{(CNT_W-1){1'b0}}, s_smp[i]};
                end
                ovf_cnt_d = ovf_cnt_q + {{(CNT_W-1){1'b0}}, ovf_smp};
`ifdef PBIT_CONSISTENCY_CHECK_EN
                hit_cnt_d = hit_cnt_q + {{(CNT_W-1){1'b0}}, pair_hit};
`endif
                if (phase_q == win_q - ONE) begin
                    state_d = DECIDE;
                end else begin
                    phase_d = phase_q + ONE;
                end
            end

            DECIDE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    a_dec_d[i] = majority(a_cnt_q[i], win_q);
                    b_dec_d[i] = majority(b_cnt_q[i], win_q);
                    s_dec_d[i] = majority(s_cnt_q[i], win_q);
                end
                ovf_dec_d = majority(ovf_cnt_q, win_q);
`ifdef PBIT_CONSISTENCY_CHECK_EN
                hit_count_d = hit_cnt_q;
`endif
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the vote counters are ordinary flops, not a memory, and are cleared
            // here so a run abandoned by reset leaves no stale tallies behind.
            state_q       <= IDLE;
            phase_q       <= '0;
            win_q         <= ONE;
            adder_reset_q <= 1'b0;
            done_q        <= 1'b0;
            a_cnt_q       <= '0;
            b_cnt_q       <= '0;
            s_cnt_q       <= '0;
            ovf_cnt_q     <= '0;
            a_dec_q       <= '0;
            b_dec_q       <= '0;
            s_dec_q       <= '0;
            ovf_dec_q     <= 1'b0;
`ifdef PBIT_CONSISTENCY_CHECK_EN
            hit_cnt_q     <= '0;
            hit_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            win_q         <= win_d;
            adder_reset_q <= adder_reset_d;
            done_q        <= done_d;
            a_cnt_q       <= a_cnt_d;
            b_cnt_q       <= b_cnt_d;
            s_cnt_q       <= s_cnt_d;
            ovf_cnt_q     <= ovf_cnt_d;
            a_dec_q       <= a_dec_d;
            b_dec_q       <= b_dec_d;
            s_dec_q       <= s_dec_d;
            ovf_dec_q     <= ovf_dec_d;
`ifdef PBIT_CONSISTENCY_CHECK_EN
            hit_cnt_q     <= hit_cnt_d;
            hit_count_q   <= hit_count_d;
`endif
        end
    end

    assign adder_reset = adder_reset_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign a_dec       = a_dec_q;
    assign b_dec       = b_dec_q;
    assign s_dec       = s_dec_q;
    assign ovf_dec     = ovf_dec_q;
`ifdef PBIT_CONSISTENCY_CHECK_EN
    assign hit_count   = hit_count_q;
`else
    assign hit_count   = '0;
`endif

endmodule

// File: tb/tb_pbit_sample_decoder.sv
// Self-checking bench for pbit_sample_decoder: a run-level reference model built from the
// sample history plus literal expectations for the directed scenarios.
module tb_pbit_sample_decoder;

    localparam int WIDTH   = 4;
    localparam int CNT_W   = 16;
    localparam int BURN_IN = 2;
    localparam int HIST    = 16384;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             ovf;
    } smp_t;

`ifdef PBIT_CONSISTENCY_CHECK_EN
    localparam bit HIT_ON = 1'b1;
`else
    localparam bit HIT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] window;
    logic [WIDTH-1:0] a_smp, b_smp, s_smp;
    logic             ovf_smp;
    logic             adder_reset, busy, done;
    logic [WIDTH-1:0] a_dec, b_dec, s_dec;
    logic             ovf_dec;
    logic [CNT_W-1:0] hit_count;

    pbit_sample_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W), .BURN_IN(BURN_IN)) dut (
        .clk(clk), .reset(reset), .start(start), .window(window),
        .a_smp(a_smp), .b_smp(b_smp), .s_smp(s_smp), .ovf_smp(ovf_smp),
        .adder_reset(adder_reset), .busy(busy), .done(done),
        .a_dec(a_dec), .b_dec(b_dec), .s_dec(s_dec), .ovf_dec(ovf_dec),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    int   cyc = 0;
    smp_t hist [HIST];
    smp_t seq [$];

    // Reference model state: one run at a time, described by its start edge and window.
    bit               m_active = 1'b0;
    bit               m_done = 1'b0;
    bit               m_arst = 1'b0;
    int               m_e0 = 0;
    int               m_w = 1;
    logic [3*WIDTH:0] m_dec = '0;
    logic [CNT_W-1:0] m_hit = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic smp_t rnd_smp();
        logic [31:0] r;
        r = $urandom;
        return r[3*WIDTH:0];
    endfunction

    task automatic drive(input smp_t v);
        a_smp   = v.a;
        b_smp   = v.b;
        s_smp   = v.s;
        ovf_smp = v.ovf;
    endtask

    // Model: at every edge record the samples; decide acceptance, completion and the vote.
    always @(posedge clk) begin : model
        int k;
        int ca [3*WIDTH+1];
        int hits;
        k = cyc;
        if (k < HIST) hist[k] = {a_smp, b_smp, s_smp, ovf_smp};
        m_done = 1'b0;
        m_arst = 1'b0;
        if (reset !== 1'b1) begin
            m_active = 1'b0;
            m_dec    = '0;
            m_hit    = '0;
        end else if (m_active) begin
            if (k == m_e0 + 2 + BURN_IN + m_w) begin
                for (int i = 0; i <= 3*WIDTH; i++) ca[i] = 0;
                hits = 0;
                for (int e = m_e0 + 2 + BURN_IN; e <= m_e0 + 1 + BURN_IN + m_w; e++) begin
                    for (int i = 0; i <= 3*WIDTH; i++) ca[i] += int'(hist[e][i]);
                    if (int'(hist[e].a) + int'(hist[e].b) == int'({hist[e].ovf, hist[e].s})) hits++;
                end
                for (int i = 0; i <= 3*WIDTH; i++) m_dec[i] = (2 * ca[i] > m_w);
                m_hit    = HIT_ON ? CNT_W'(hits) : '0;
                m_done   = 1'b1;
                m_active = 1'b0;
            end
        end else if (start === 1'b1) begin
            m_active = 1'b1;
            m_e0     = k;
            m_w      = (window == '0) ? 1 : int'(window);
            m_arst   = 1'b1;
        end
        cyc = k + 1;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ctrl", {61'd0, busy, done, adder_reset}, {61'd0, m_active, m_done, m_arst});
            check("dec", {a_dec, b_dec, s_dec, ovf_dec, hit_count}, {m_dec, m_hit});
        end
    end

    // Launch a run from the current negedge; samples come from seq (random beyond its end).
    task automatic run_seq(input int wcfg, input smp_t flush_v, input bit restart_mid, output int e0);
        int weff;
        weff   = (wcfg == 0) ? 1 : wcfg;
        start  = 1'b1;
        window = CNT_W'(wcfg);
        drive(flush_v);
        @(negedge clk);
        start  = 1'b0;
        window = CNT_W'($urandom_range(0, 40));
        e0     = cyc - 1;
        check("arst_first", {63'd0, adder_reset}, 64'd1);
        for (int j = 0; j <= BURN_IN; j++) begin
            drive(flush_v);
            @(negedge clk);
            if (j == 0) check("arst_second", {63'd0, adder_reset}, 64'd0);
        end
        for (int j = 0; j < weff; j++) begin
            drive(j < seq.size() ? seq[j] : rnd_smp());
            if (restart_mid && j == weff / 2) begin
                start  = 1'b1;
                window = CNT_W'(3);
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_done(input int e0, output int lat);
        lat = -1;
        for (int n = 0; n < 64; n++) begin
            if (done === 1'b1) begin
                lat = cyc - 1 - e0;
                break;
            end
            drive(rnd_smp());
            @(negedge clk);
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    initial begin
        int   e0, lat, w;
        bit   seen;
        smp_t v;

        reset = 1'b0; start = 1'b0; window = '0;
        drive('0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ctrl", {61'd0, busy, done, adder_reset}, 64'd0);
        check("rst_dec", {a_dec, b_dec, s_dec, ovf_dec, hit_count}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Constant adder answer 1+7=8.
        seq.delete();
        for (int j = 0; j < 10; j++) seq.push_back({4'd1, 4'd7, 4'd8, 1'b0});
        run_seq(10, {4'd1, 4'd7, 4'd8, 1'b0}, 1'b0, e0);
        wait_done(e0, lat);
        check("t1_latency", 64'(lat), 64'd14);
        check("t1_dec", {51'd0, a_dec, b_dec, s_dec, ovf_dec}, {51'd0, 4'd1, 4'd7, 4'd8, 1'b0});
        check("t1_hit", 64'(hit_count), HIT_ON ? 64'd10 : 64'd0);

        // Tie decodes to 0; strict majority decodes to 1.
        seq.delete();
        for (int j = 0; j < 4; j++) seq.push_back({4'd0, 4'd0, 3'd0, ~j[0], 1'b0});
        run_seq(4, rnd_smp(), 1'b0, e0);
        wait_done(e0, lat);
        check("tie_w4", {51'd0, a_dec, b_dec, s_dec, ovf_dec}, 64'd0);
        seq.delete();
        for (int j = 0; j < 5; j++) seq.push_back({4'd0, 4'd0, 3'd0, ~j[0], 1'b0});
        run_seq(5, rnd_smp(), 1'b0, e0);
        wait_done(e0, lat);
        check("tie_w5", {51'd0, a_dec, b_dec, s_dec, ovf_dec}, {51'd0, 4'd0, 4'd0, 4'd1, 1'b0});

        // Burn-in samples must not leak into the vote.
        seq.delete();
        for (int j = 0; j < 8; j++) seq.push_back('0);
        run_seq(8, {4'hF, 4'hF, 4'hF, 1'b1}, 1'b0, e0);
        wait_done(e0, lat);
        check("burnin_dec", {51'd0, a_dec, b_dec, s_dec, ovf_dec}, 64'd0);
        check("burnin_hit", 64'(hit_count), HIT_ON ? 64'd8 : 64'd0);

        // Start while busy is ignored; start in the done cycle launches a new run.
        seq.delete();
        run_seq(10, rnd_smp(), 1'b1, e0);
        wait_done(e0, lat);
        check("busy_start_latency", 64'(lat), 64'd14);
        start = 1'b1; window = CNT_W'(2); drive(rnd_smp());
        @(negedge clk);
        start = 1'b0;
        e0 = cyc - 1;
        check("done_cycle_start_busy", {63'd0, busy}, 64'd1);
        wait_done(e0, lat);
        check("b2b_latency", 64'(lat), 64'd6);

        // Reset mid-SAMPLE abandons the run.
        start = 1'b1; window = CNT_W'(10);
        @(negedge clk);
        start = 1'b0;
        repeat (6) begin drive(rnd_smp()); @(negedge clk); end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_ctrl", {61'd0, busy, done, adder_reset}, 64'd0);
        check("midrst_dec", {a_dec, b_dec, s_dec, ovf_dec, hit_count}, 64'd0);
        seen = 1'b0;
        repeat (20) begin
            drive(rnd_smp());
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("midrst_no_done", {63'd0, seen}, 64'd0);

        // window=0 behaves as a single-sample window.
        v = rnd_smp();
        seq.delete();
        seq.push_back(v);
        run_seq(0, rnd_smp(), 1'b0, e0);
        wait_done(e0, lat);
        check("w0_latency", 64'(lat), 64'd5);
        check("w0_dec", {51'd0, a_dec, b_dec, s_dec, ovf_dec}, {51'd0, v});

        // Random back-to-back runs, each starting in the previous run's done cycle.
        for (int r = 0; r < 30; r++) begin
            w = $urandom_range(0, 12);
            v = rnd_smp();
            seq.delete();
            for (int j = 0; j < 12; j++) seq.push_back(($urandom_range(0, 3) == 0) ? rnd_smp() : v);
            run_seq(w, rnd_smp(), ($urandom_range(0, 3) == 0) && (w >= 2), e0);
            wait_done(e0, lat);
            check("rand_latency", 64'(lat), 64'(2 + BURN_IN + ((w == 0) ? 1 : w)));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pbit_sample_decoder.md
# pbit_sample_decoder

Reads the stochastic p-bit outputs of the invertible ripple adder (a, b, sum, overflow samples) and turns them into settled binary words by per-bit majority vote over a programmable sampling window. On `start` it pulses the adder's reset, discards a burn-in interval, and counts ones per bit for `window` cycles. It then reports the decoded words with a one-cycle `done` pulse. It sits between the adder array and any host or test logic that needs a deterministic answer out of the annealing network.

## Interface
- `WIDTH`, 4, adder word width (bits per a/b/sum sample)
- `CNT_W`, 16, width of window length and per-bit ones counters
- `BURN_IN`, 2, samples discarded after the adder reset pulse before counting starts
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  request a decode run; honoured only in IDLE
- `window`  in  CNT_W  number of samples to count; latched on accepted `start`
- `a_smp`, `b_smp`, `s_smp`  in  WIDTH each  per-cycle p-bit samples from the adder
- `ovf_smp`  in  1  per-cycle overflow (MSB carry-out) sample
- `adder_reset`  out  1  high for exactly one cycle to reinitialise the adder p-bits
- `busy`  out  1  high from the cycle after an accepted `start` until the decision is made
- `done`  out  1  one-cycle pulse; decoded outputs valid from this cycle
- `a_dec`, `b_dec`, `s_dec`  out  WIDTH each  majority-decoded words
- `ovf_dec`  out  1  majority-decoded overflow
- `hit_count`  out  CNT_W  samples in window where a+b equals {ovf,s} (see Configuration)

## Operation
- FSM states: IDLE, FLUSH, SAMPLE, DECIDE.
- IDLE to FLUSH: when `start`=1. Latch `window`. A latched value of 0 is treated as 1. Clear all counters.
- FLUSH lasts 1+BURN_IN cycles. `adder_reset`=1 in the first FLUSH cycle only. Samples are ignored.
- SAMPLE lasts exactly the latched window W cycles. Each cycle, each of the 3·WIDTH+1 counters increments by its sample bit.
- Counters hold at most W, so they cannot overflow. No wrap or saturation logic is needed.
- DECIDE lasts 1 cycle. For each bit, output is 1 iff 2·count > W, with the comparison at CNT_W+1 bits. A tie decodes to 0.
- DECIDE then returns to IDLE. The decoded outputs register on that edge, and `done` is high in the first IDLE cycle.
- Decoded outputs hold their value until the next DECIDE or until reset.
- `start` while `busy` is ignored: no restart and no queueing.
- `start` in the same cycle `done` is high is accepted normally.
- Input samples are sampled as-is. The adder's pipeline alignment is absorbed by BURN_IN.

## Timing
- Reset (`reset`=0 at an edge): state IDLE. `busy`, `done`, `adder_reset`, `a_dec`, `b_dec`, `s_dec`, `ovf_dec`, `hit_count` and all counters are 0. The latched window is 1.
- Reset takes effect mid-run in any state. The run is abandoned, no `done` is issued, and any `adder_reset` pulse in progress is dropped.
- Accepted `start` at edge E0:
  - `busy` and `adder_reset` rise after E0.
  - `done` is high for the single cycle after edge E0+2+BURN_IN+W.
  - `busy` falls on that same edge.
- Latency from start to done, in cycles: 2+BURN_IN+W. Default BURN_IN=2 gives W+4.
- Back-to-back throughput: one run per 3+BURN_IN+W cycles.

## Configuration
- `PBIT_CONSISTENCY_CHECK_EN` defined:
  - During SAMPLE, a CNT_W counter increments each cycle where the WIDTH+1-bit sum a_smp+b_smp equals {ovf_smp,s_smp}.
  - The counter is cleared on accepted start.
  - `hit_count` registers it in DECIDE, alongside the decoded words.
- Not defined: no adder or comparator is instantiated, and `hit_count` is constant 0.

## Test plan
- Constant samples a=1, b=7, s=8, ovf=0, W=10, default params. Expect `done` 14 cycles after the start edge, with a_dec=1, b_dec=7, s_dec=8, ovf_dec=0, and `adder_reset` high only in cycle 1. With the macro on, hit_count=10.
- Tie rule: W=4, s_smp bit0 pattern 1,0,1,0, other bits 0. Expect s_dec=0. Repeat with W=5 and pattern 1,0,1,0,1: expect s_dec=1.
- Burn-in discard: all samples 0xF (ovf=1) during FLUSH, then 0 during SAMPLE, W=8. Expect all decoded outputs 0.
- Start while busy: second `start` pulse mid-SAMPLE. Expect a single `done` at the original time and `window` unchanged. A start asserted in the `done` cycle launches a new run, with `busy` high on the next cycle.
- Reset mid-run: drive `reset`=0 for one edge during SAMPLE. Expect all outputs 0 and state IDLE, with no `done` until a new start.
- window=0: expect behaviour identical to W=1, with `done` 5 cycles after start and outputs equal to the first SAMPLE-cycle sample.
